// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with EX/MEM and MEM/WB forwarding and load-use bubbles
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Stall,
  input  logic             Flush,
  input  logic             IdValid,
  input  logic [2:0]       IdALUCtl,
  input  logic [4:0]       IdShamt,
  input  logic [WIDTH-1:0] IdRsData,
  input  logic [WIDTH-1:0] IdRtData,
  input  logic [WIDTH-1:0] IdImm,
  input  logic [REGW-1:0]  IdRs,
  input  logic [REGW-1:0]  IdRt,
  input  logic [REGW-1:0]  IdRd,
  input  logic             IdALUSrc,
  input  logic             IdRegDst,
  input  logic             IdRegWrite,
  input  logic             IdMemRead,
  input  logic             IdMemWrite,
  input  logic             IdMemToReg,
  input  logic             ExMemRegWrite,
  input  logic [REGW-1:0]  ExMemDest,
  input  logic [WIDTH-1:0] ExMemResult,
  input  logic             MemWbRegWrite,
  input  logic [REGW-1:0]  MemWbDest,
  input  logic [WIDTH-1:0] MemWbData,
  output logic             LoadUse,
  output logic             ExValid,
  output logic [2:0]       ExCtl,
  output logic [4:0]       ExShamt,
  output logic [WIDTH-1:0] ExDataA,
  output logic [WIDTH-1:0] ExDataB,
  output logic [WIDTH-1:0] ExStoreData,
  output logic [REGW-1:0]  ExDest,
  output logic             ExRegWrite,
  output logic             ExMemRead,
  output logic             ExMemWrite,
  output logic             ExMemToReg
);

  logic             r_valid;
  logic [2:0]       r_ctl;
  logic [4:0]       r_shamt;
  logic [WIDTH-1:0] r_rs_data;
  logic [WIDTH-1:0] r_rt_data;
  logic [WIDTH-1:0] r_imm;
  logic [REGW-1:0]  r_rs;
  logic [REGW-1:0]  r_rt;
  logic [REGW-1:0]  r_dest;
  logic             r_alusrc;
  logic             r_regwrite;
  logic             r_memread;
  logic             r_memwrite;
  logic             r_memtoreg;

  logic             w_load_use;
  logic [WIDTH-1:0] w_fwd_a;
  logic [WIDTH-1:0] w_fwd_b;

  // Only a valid load in EX writing a nonzero register can stall a dependent ID instruction.
  assign w_load_use = r_valid && r_memread && (r_dest != '0) && IdValid &&
                      ((r_dest == IdRs) || (r_dest == IdRt)) && !Flush;

  always_ff @(posedge clk) begin
    if (rst || Flush || (!Stall && w_load_use)) begin
      r_valid    <= 1'b0;
      r_ctl      <= '0;
      r_shamt    <= '0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_imm      <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_dest     <= '0;
      r_alusrc   <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_memtoreg <= 1'b0;
    end else if (!Stall) begin
      r_valid    <= IdValid;
      r_ctl      <= IdALUCtl;
      r_shamt    <= IdShamt;
      r_rs_data  <= IdRsData;
      r_rt_data  <= IdRtData;
      r_imm      <= IdImm;
      r_rs       <= IdRs;
      r_rt       <= IdRt;
      r_dest     <= IdRegDst ? IdRd : IdRt;
      r_alusrc   <= IdALUSrc;
      r_regwrite <= IdRegWrite;
      r_memread  <= IdMemRead;
      r_memwrite <= IdMemWrite;
      r_memtoreg <= IdMemToReg;
    end
  end

  // Younger producer (EX/MEM) wins; register 0 is hardwired and never forwarded.
  always_comb begin
    w_fwd_a = r_rs_data;
    if (ExMemRegWrite && (ExMemDest != '0) && (ExMemDest == r_rs))
      w_fwd_a = ExMemResult;
    else if (MemWbRegWrite && (MemWbDest != '0) && (MemWbDest == r_rs))
      w_fwd_a = MemWbData;
  end

  always_comb begin
    w_fwd_b = r_rt_data;
    if (ExMemRegWrite && (ExMemDest != '0) && (ExMemDest == r_rt))
      w_fwd_b = ExMemResult;
    else if (MemWbRegWrite && (MemWbDest != '0) && (MemWbDest == r_rt))
      w_fwd_b = MemWbData;
  end

  assign LoadUse     = w_load_use;
  assign ExValid     = r_valid;
  assign ExCtl       = r_ctl;
  assign ExShamt     = r_shamt;
  assign ExDataA     = w_fwd_a;
  assign ExDataB     = r_alusrc ? r_imm : w_fwd_b;
  assign ExStoreData = w_fwd_b;
  assign ExDest      = r_dest;
  assign ExRegWrite  = r_valid & r_regwrite;
  assign ExMemRead   = r_valid & r_memread;
  assign ExMemWrite  = r_valid & r_memwrite;
  assign ExMemToReg  = r_valid & r_memtoreg;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
  localparam int WIDTH = 32;
  localparam int REGW  = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             Stall, Flush, IdValid;
  logic [2:0]       IdALUCtl;
  logic [4:0]       IdShamt;
  logic [WIDTH-1:0] IdRsData, IdRtData, IdImm;
  logic [REGW-1:0]  IdRs, IdRt, IdRd;
  logic             IdALUSrc, IdRegDst, IdRegWrite, IdMemRead, IdMemWrite, IdMemToReg;
  logic             ExMemRegWrite;
  logic [REGW-1:0]  ExMemDest;
  logic [WIDTH-1:0] ExMemResult;
  logic             MemWbRegWrite;
  logic [REGW-1:0]  MemWbDest;
  logic [WIDTH-1:0] MemWbData;
  logic             LoadUse, ExValid;
  logic [2:0]       ExCtl;
  logic [4:0]       ExShamt;
  logic [WIDTH-1:0] ExDataA, ExDataB, ExStoreData;
  logic [REGW-1:0]  ExDest;
  logic             ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.WIDTH(WIDTH), .REGW(REGW)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .IdValid(IdValid),
    .IdALUCtl(IdALUCtl), .IdShamt(IdShamt), .IdRsData(IdRsData), .IdRtData(IdRtData),
    .IdImm(IdImm), .IdRs(IdRs), .IdRt(IdRt), .IdRd(IdRd), .IdALUSrc(IdALUSrc),
    .IdRegDst(IdRegDst), .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead),
    .IdMemWrite(IdMemWrite), .IdMemToReg(IdMemToReg), .ExMemRegWrite(ExMemRegWrite),
    .ExMemDest(ExMemDest), .ExMemResult(ExMemResult), .MemWbRegWrite(MemWbRegWrite),
    .MemWbDest(MemWbDest), .MemWbData(MemWbData), .LoadUse(LoadUse), .ExValid(ExValid),
    .ExCtl(ExCtl), .ExShamt(ExShamt), .ExDataA(ExDataA), .ExDataB(ExDataB),
    .ExStoreData(ExStoreData), .ExDest(ExDest), .ExRegWrite(ExRegWrite),
    .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite), .ExMemToReg(ExMemToReg)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic id_idle();
    IdValid = 0; IdALUCtl = 0; IdShamt = 0; IdRsData = 0; IdRtData = 0; IdImm = 0;
    IdRs = 0; IdRt = 0; IdRd = 0; IdALUSrc = 0; IdRegDst = 0; IdRegWrite = 0;
    IdMemRead = 0; IdMemWrite = 0; IdMemToReg = 0;
  endtask

  task automatic fwd_idle();
    ExMemRegWrite = 0; ExMemDest = 0; ExMemResult = 0;
    MemWbRegWrite = 0; MemWbDest = 0; MemWbData = 0;
  endtask

  task automatic test_reset();
    rst = 1; Stall = 0; Flush = 0;
    id_idle(); fwd_idle();
    IdValid = 1; IdRs = 1; IdRsData = 32'hA; IdRegWrite = 1; IdMemRead = 1; IdRt = 2; IdALUCtl = 3'b110;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (ExValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", ExValid); end
    n_checks++; if (ExCtl !== 3'b000) begin n_fail++; $display("FAIL reset_ctl got %b exp 000", ExCtl); end
    n_checks++; if ({ExDataA, ExDataB, ExStoreData} !== 96'h0) begin n_fail++; $display("FAIL reset_data got %h %h %h exp 0", ExDataA, ExDataB, ExStoreData); end
    n_checks++; if ({ExDest, ExShamt, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg} !== 14'h0) begin n_fail++; $display("FAIL reset_ctrl got %h %h %b%b%b%b exp 0", ExDest, ExShamt, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg); end
    n_checks++; if (LoadUse !== 1'b0) begin n_fail++; $display("FAIL reset_loaduse got %b exp 0", LoadUse); end
    rst = 0;
    tick();
    n_checks++; if (ExValid !== 1'b1 || ExDataA !== 32'hA || ExCtl !== 3'b110) begin n_fail++; $display("FAIL reset_release got v=%b a=%h c=%b exp v=1 a=a c=110", ExValid, ExDataA, ExCtl); end
  endtask

  task automatic test_plain_capture();
    id_idle();
    IdValid = 1; IdALUCtl = 3'b010; IdShamt = 5'd7; IdRs = 3; IdRsData = 5; IdRt = 4; IdRtData = 7;
    IdRd = 6; IdRegDst = 1; IdRegWrite = 1;
    tick();
    n_checks++; if (ExCtl !== 3'b010 || ExShamt !== 5'd7) begin n_fail++; $display("FAIL plain_ctl got %b/%0d exp 010/7", ExCtl, ExShamt); end
    n_checks++; if (ExDataA !== 32'd5 || ExDataB !== 32'd7 || ExStoreData !== 32'd7) begin n_fail++; $display("FAIL plain_data got %h %h %h exp 5 7 7", ExDataA, ExDataB, ExStoreData); end
    n_checks++; if (ExValid !== 1'b1 || ExDest !== 5'd6 || ExRegWrite !== 1'b1 || ExMemRead !== 1'b0) begin n_fail++; $display("FAIL plain_ctrl got v=%b d=%0d rw=%b mr=%b exp 1 6 1 0", ExValid, ExDest, ExRegWrite, ExMemRead); end
  endtask

  task automatic test_forward_priority();
    id_idle();
    IdValid = 1; IdRs = 8; IdRsData = 32'h55; IdRt = 10; IdRtData = 32'h66;
    tick();
    id_idle();
    ExMemRegWrite = 1; ExMemDest = 8; ExMemResult = 32'h11;
    MemWbRegWrite = 1; MemWbDest = 8; MemWbData = 32'h22;
    #1;
    n_checks++; if (ExDataA !== 32'h11) begin n_fail++; $display("FAIL fwd_exmem got %h exp 11", ExDataA); end
    ExMemRegWrite = 0; #1;
    n_checks++; if (ExDataA !== 32'h22) begin n_fail++; $display("FAIL fwd_memwb got %h exp 22", ExDataA); end
    MemWbDest = 10; #1;
    n_checks++; if (ExDataB !== 32'h22 || ExDataA !== 32'h55) begin n_fail++; $display("FAIL fwd_rt got b=%h a=%h exp 22 55", ExDataB, ExDataA); end
    ExMemRegWrite = 1; ExMemDest = 0; MemWbDest = 0; #1;
    n_checks++; if (ExDataA !== 32'h55 || ExDataB !== 32'h66) begin n_fail++; $display("FAIL fwd_dest0 got %h %h exp 55 66", ExDataA, ExDataB); end
    fwd_idle();
    IdValid = 1; IdRs = 0; IdRsData = 32'h77;
    tick();
    ExMemRegWrite = 1; ExMemDest = 0; ExMemResult = 32'h11;
    MemWbRegWrite = 1; MemWbDest = 0; MemWbData = 32'h22; #1;
    n_checks++; if (ExDataA !== 32'h77) begin n_fail++; $display("FAIL fwd_reg0 got %h exp 77", ExDataA); end
    fwd_idle();
  endtask

  task automatic test_load_use();
    id_idle();
    IdValid = 1; IdMemRead = 1; IdRegWrite = 1; IdMemToReg = 1; IdRt = 9; IdRs = 1; IdALUSrc = 1; IdImm = 4;
    tick();
    n_checks++; if (ExDest !== 5'd9 || ExMemRead !== 1'b1 || ExMemToReg !== 1'b1) begin n_fail++; $display("FAIL lw_capture got d=%0d mr=%b m2r=%b exp 9 1 1", ExDest, ExMemRead, ExMemToReg); end
    id_idle();
    IdValid = 1; IdRs = 2; IdRt = 9; #1;
    n_checks++; if (LoadUse !== 1'b1) begin n_fail++; $display("FAIL lu_rt got %b exp 1", LoadUse); end
    Flush = 1; #1;
    n_checks++; if (LoadUse !== 1'b0) begin n_fail++; $display("FAIL lu_flush got %b exp 0", LoadUse); end
    Flush = 0;
    IdValid = 0; #1;
    n_checks++; if (LoadUse !== 1'b0) begin n_fail++; $display("FAIL lu_invalid got %b exp 0", LoadUse); end
    IdValid = 1; IdRs = 9; IdRt = 2; IdRsData = 32'h99; IdALUCtl = 3'b001; IdRegWrite = 1; IdRegDst = 1; IdRd = 12; #1;
    n_checks++; if (LoadUse !== 1'b1) begin n_fail++; $display("FAIL lu_rs got %b exp 1", LoadUse); end
    tick();
    n_checks++; if ({ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg} !== 5'b0 || ExDest !== 5'd0 || LoadUse !== 1'b0) begin n_fail++; $display("FAIL lu_bubble got v=%b ctl=%b%b%b%b d=%0d lu=%b exp all 0", ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg, ExDest, LoadUse); end
    tick();
    n_checks++; if (ExValid !== 1'b1 || ExDest !== 5'd12 || ExCtl !== 3'b001 || ExDataA !== 32'h99 || ExRegWrite !== 1'b1) begin n_fail++; $display("FAIL lu_resume got v=%b d=%0d c=%b a=%h rw=%b exp 1 12 001 99 1", ExValid, ExDest, ExCtl, ExDataA, ExRegWrite); end
  endtask

  task automatic test_stall_flush();
    id_idle();
    IdValid = 1; IdRs = 1; IdRsData = 32'hBAD; IdALUCtl = 3'b111; IdRd = 3; IdRegDst = 1; IdMemWrite = 1;
    Stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (ExValid !== 1'b1 || ExDest !== 5'd12 || ExCtl !== 3'b001 || ExDataA !== 32'h99 || ExRegWrite !== 1'b1 || ExMemWrite !== 1'b0) begin n_fail++; $display("FAIL stall_hold%0d got v=%b d=%0d c=%b a=%h rw=%b mw=%b exp 1 12 001 99 1 0", i, ExValid, ExDest, ExCtl, ExDataA, ExRegWrite, ExMemWrite); end
    end
    MemWbRegWrite = 1; MemWbDest = 9; MemWbData = 32'h1234; #1;
    n_checks++; if (ExDataA !== 32'h1234) begin n_fail++; $display("FAIL stall_fwd got %h exp 1234", ExDataA); end
    fwd_idle();
    Flush = 1;
    tick();
    n_checks++; if (ExValid !== 1'b0 || ExCtl !== 3'b000 || ExDest !== 5'd0 || ExDataA !== 32'h0 || ExRegWrite !== 1'b0) begin n_fail++; $display("FAIL stall_flush got v=%b c=%b d=%0d a=%h rw=%b exp all 0", ExValid, ExCtl, ExDest, ExDataA, ExRegWrite); end
    Flush = 0; Stall = 0;
  endtask

  task automatic test_alusrc();
    id_idle();
    IdValid = 1; IdALUSrc = 1; IdImm = 32'hFFFFFFFC; IdRt = 5; IdRtData = 32'h44; IdMemWrite = 1;
    ExMemRegWrite = 1; ExMemDest = 5; ExMemResult = 32'h33;
    tick();
    n_checks++; if (ExDataB !== 32'hFFFFFFFC || ExStoreData !== 32'h33) begin n_fail++; $display("FAIL alusrc got b=%h sd=%h exp fffffffc 33", ExDataB, ExStoreData); end
    n_checks++; if (ExMemWrite !== 1'b1 || ExDest !== 5'd5) begin n_fail++; $display("FAIL alusrc_ctrl got mw=%b d=%0d exp 1 5", ExMemWrite, ExDest); end
    fwd_idle();
  endtask

  task automatic test_invalid_gating();
    id_idle();
    IdValid = 0; IdRegWrite = 1; IdMemRead = 1; IdMemWrite = 1; IdMemToReg = 1; IdRegDst = 1; IdRd = 7;
    tick();
    n_checks++; if ({ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg} !== 5'b0 || ExDest !== 5'd7) begin n_fail++; $display("FAIL invalid_gate got v=%b ctl=%b%b%b%b d=%0d exp 0 0000 7", ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg, ExDest); end
    id_idle();
    IdValid = 1; IdRs = 7; #1;
    n_checks++; if (LoadUse !== 1'b0) begin n_fail++; $display("FAIL invalid_lu got %b exp 0", LoadUse); end
  endtask

  initial begin
    test_reset();
    test_plain_capture();
    test_forward_priority();
    test_load_use();
    test_stall_flush();
    test_alusrc();
    test_invalid_gating();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register for the 5-stage MIPS pipeline. It sits directly upstream of the EX-stage ALU and feeds its Ctl, shamt, DataA and DataB inputs. It latches decoded operands and control each cycle and resolves EX/MEM and MEM/WB forwarding onto the ALU operands. It also detects load-use hazards and inserts bubbles, and supports external stall and flush.

Parameters:
WIDTH, 32, datapath width of operands and immediate
REGW, 5, register-address width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
Stall  in  1  hold all stage registers (external memory stall)
Flush  in  1  replace the captured instruction with a bubble (branch/jump redirect)
IdValid  in  1  ID instruction is valid
IdALUCtl  in  3  ALU control {invertB, sel[1:0]}
IdShamt  in  5  shift amount
IdRsData, IdRtData, IdImm  in  WIDTH  register-file reads and sign-extended immediate
IdRs, IdRt, IdRd  in  REGW  source and destination register numbers
IdALUSrc, IdRegDst, IdRegWrite, IdMemRead, IdMemWrite, IdMemToReg  in  1  decoded control
ExMemRegWrite  in  1  EX/MEM writes a register
ExMemDest  in  REGW  EX/MEM destination register
ExMemResult  in  WIDTH  EX/MEM ALU result
MemWbRegWrite  in  1  MEM/WB writes a register
MemWbDest  in  REGW  MEM/WB destination register
MemWbData  in  WIDTH  MEM/WB write-back data
LoadUse  out  1  load-use hazard; the IF/ID stage must hold
ExValid  out  1  registered valid
ExCtl  out  3  to ALU Ctl
ExShamt  out  5  to ALU shamt
ExDataA  out  WIDTH  to ALU DataA (forwarded Rs)
ExDataB  out  WIDTH  to ALU DataB (IdImm if ALUSrc, else forwarded Rt)
ExStoreData  out  WIDTH  forwarded Rt for stores
ExDest  out  REGW  registered destination: Rd if RegDst, else Rt
ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg  out  1  registered control, gated by valid

Behaviour:
- Reset: every registered field is cleared to 0, including ExValid, all control bits, ExCtl, ExShamt, ExDest, the operand registers and the stored Rs/Rt. After reset ExDataA = ExDataB = ExStoreData = 0 unless forwarding matches register 0, which never occurs.
- Update priority on each rising edge: rst > Flush > Stall > LoadUse > normal load.
  - Flush: load a bubble (all fields 0).
  - Stall: hold every register unchanged.
  - LoadUse: load a bubble.
  - Normal: capture all Id* fields; ExDest is computed at capture; valid = IdValid.
- Flush and Stall asserted together: Flush wins.
- Bubble or invalid instruction: the Ex control outputs RegWrite, MemRead, MemWrite and MemToReg are 0. A bubble has no architectural side effect.
- LoadUse is combinational from the registered state and the ID inputs:
  - LoadUse = ExValid & ExMemRead & (ExDest != 0) & IdValid & ((ExDest == IdRs) | (ExDest == IdRt)).
  - It is forced to 0 while Flush is asserted.
- Forwarding is combinational from the registered stored Rs/Rt; the same rule applies to Rt:
  - if ExMemRegWrite and ExMemDest != 0 and ExMemDest == stored Rs, forward ExMemResult;
  - else if MemWbRegWrite and MemWbDest != 0 and MemWbDest == stored Rs, forward MemWbData;
  - else use the latched IdRsData.
  - EX/MEM has priority over MEM/WB.
  - Register 0 is never forwarded.
- ExDataB = ALUSrc ? latched IdImm : forwarded Rt. ExStoreData always carries the forwarded Rt.
- Forwarding stays live during Stall, so the operands track newer producers while the stage holds.
- Latency: 1 cycle from ID inputs to Ex outputs. The forwarding path has zero latency.
- No arithmetic is performed in this block. Widths pass through unchanged.

Test Plan:
- Reset: assert rst for 2 cycles with IdValid=1 driven -> all Ex outputs 0 and LoadUse 0. First edge after release captures the ID inputs.
- Plain capture: ALUCtl=3'b010, Rs=3 (data 5), Rt=4 (data 7), ALUSrc=0, no forwarding -> next cycle ExCtl=010, ExDataA=5, ExDataB=7, ExValid=1.
- Forward priority: stored Rs=8; ExMemDest=8, ExMemResult=0x11, MemWbDest=8, MemWbData=0x22, both writes=1 -> ExDataA=0x11. Drop ExMemRegWrite -> ExDataA=0x22. Set both Dest=0 -> latched data.
- Load-use: EX holds lw with ExDest=9 and MemRead=1; ID has Rs=9 -> LoadUse=1, next cycle ExValid=0 with all control 0. The following cycle the held instruction is captured normally.
- Stall and Flush: Stall=1 for 3 cycles -> outputs hold bit-exact. Stall=1 with Flush=1 -> bubble loaded.
- ALUSrc path: ALUSrc=1, Imm=0xFFFFFFFC, Rt forwarded 0x33 -> ExDataB=0xFFFFFFFC and ExStoreData=0x33.
